// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage core: load-use stalls, branch flushes,
// dmem request/ready handshake with timeout, and saturating event counters.
module satCounter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module hazard_stall_controller #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             PCSrcE,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_fault,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mw_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [1:0] state, stateNext;
  logic [7:0] waitCnt;
  logic       memop, lu, reqRaw, ms;

  assign memop  = MemReadM | MemWriteM;
  assign lu     = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign reqRaw = ((state == IDLE) & memop) | (state == WAIT);
  assign ms     = (reqRaw & ~dmem_ready) | (state == FAULT);

  always_comb begin
    dmem_req = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    if (!rst) begin
      dmem_req = reqRaw;
      // A memory freeze masks branch and load-use; they re-evaluate once it drops.
      if (ms) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memop && !dmem_ready) stateNext = WAIT;
      WAIT: begin
        if (dmem_ready)                stateNext = IDLE;
        else if (waitCnt == WAIT_LAST) stateNext = FAULT;
      end
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 8'd0;
      mem_fault <= 1'b0;
    end else begin
      state     <= stateNext;
      mem_fault <= mem_fault | (stateNext == FAULT);
      if (state == IDLE)                    waitCnt <= 8'd0;
      else if (state == WAIT && !dmem_ready) waitCnt <= waitCnt + 8'd1;
    end
  end

  // Event order: load-use, branch flush, memory wait.
  logic [2:0]            incVec;
  logic [2:0][CNT_W-1:0] cntVec;

  assign incVec = {ms & (state != FAULT), ~ms & PCSrcE, ~ms & ~PCSrcE & lu};

  for (genvar i = 0; i < 3; i++) begin : gCnt
    satCounter #(.W(CNT_W)) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (incVec[i]),
      .cnt (cntVec[i])
    );
  end

  assign lu_cnt = cntVec[0];
  assign br_cnt = cntVec[1];
  assign mw_cnt = cntVec[2];
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Random plus directed bench for hazard_stall_controller against a
// cycle-level behavioural model of the stall/flush/timeout rules.
module tb_hazard_stall_controller;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic MemReadE = 1'b0, PCSrcE = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0, dmem_ready = 1'b0;
  logic [4:0] RdE = '0, Rs1D = '0, Rs2D = '0;
  logic dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_fault;
  logic [CNT_W-1:0] lu_cnt, br_cnt, mw_cnt;

  hazard_stall_controller #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .PCSrcE(PCSrcE), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_fault(mem_fault),
    .lu_cnt(lu_cnt), .br_cnt(br_cnt), .mw_cnt(mw_cnt)
  );

  always #5 clk = ~clk;

  int nChk = 0;
  int nErr = 0;

  // Model: run = not-ready cycles of the access in flight (0 = none outstanding).
  int run = 0;
  bit faulted = 0;
  int luC = 0, brC = 0, mwC = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic mre, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic pc, input logic mr, input logic mw,
                      input logic rdy);
    logic       memop, luHit, req, msE;
    logic [7:0] expCtl;
    @(negedge clk);
    rst = r; MemReadE = mre; RdE = rd; Rs1D = r1; Rs2D = r2;
    PCSrcE = pc; MemReadM = mr; MemWriteM = mw; dmem_ready = rdy;
    #1;
    memop = mr | mw;
    luHit = mre && rd != 0 && (rd == r1 || rd == r2);
    req   = !faulted && (memop || run > 0);
    msE   = faulted || (req && !rdy);
    // {req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    if (r)          expCtl = 8'b0;
    else if (msE)   expCtl = {req, 7'b1111001};
    else if (pc)    expCtl = {req, 7'b0000110};
    else if (luHit) expCtl = {req, 7'b1100010};
    else            expCtl = {req, 7'b0000000};
    chk("ctl", {24'd0, dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
        {24'd0, expCtl});
    chk("memFault", 32'(mem_fault), 32'(faulted));
    chk("luCnt", 32'(lu_cnt), luC);
    chk("brCnt", 32'(br_cnt), brC);
    chk("mwCnt", 32'(mw_cnt), mwC);
    if (r) begin
      run = 0; faulted = 0; luC = 0; brC = 0; mwC = 0;
    end else begin
      if (!msE && !pc && luHit) luC = (luC < MAXC) ? luC + 1 : MAXC;
      if (!msE && pc)           brC = (brC < MAXC) ? brC + 1 : MAXC;
      if (msE && !faulted)      mwC = (mwC < MAXC) ? mwC + 1 : MAXC;
      if (!faulted && (memop || run > 0)) begin
        if (rdy) run = 0;
        else begin
          run++;
          // IDLE stall cycle plus WAIT_MAX waiting cycles exhausts the budget.
          if (run == WAIT_MAX + 1) begin faulted = 1; run = 0; end
        end
      end
    end
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    idle(1); idle(1);
    settle();
    chk("rstLu", 32'(lu_cnt), 0);
    chk("rstFault", 32'(mem_fault), 0);

    // load-use, then RdE = 0 gives no stall
    step(0, 1, 5, 0, 5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("luOnce", 32'(lu_cnt), 1);

    // branch beats load-use
    idle(1);
    step(0, 1, 7, 7, 0, 1, 0, 0, 0);
    settle();
    chk("brBr", 32'(br_cnt), 1);
    chk("brLu", 32'(lu_cnt), 0);

    // zero-wait load
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    settle();
    chk("zwMw", 32'(mw_cnt), 0);

    // 3-wait store with a pending load-use
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 3, 0, 0, 0, 1, 0);
    step(0, 1, 3, 3, 0, 0, 0, 1, 1);
    settle();
    chk("w3Mw", 32'(mw_cnt), 3);
    chk("w3Lu", 32'(lu_cnt), 1);

    // timeout
    idle(1);
    for (int i = 0; i < WAIT_MAX + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("toFault", 32'(mem_fault), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("toReq", 32'(dmem_req), 0);
    idle(1);
    settle();
    chk("toRstFault", 32'(mem_fault), 0);
    chk("toRstMw", 32'(mw_cnt), 0);

    // reset mid-WAIT
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    chk("mwReq", 32'(dmem_req), 0);
    chk("mwCnt0", 32'(mw_cnt), 0);

    // random traffic with small register range for frequent hazards
    for (int i = 0; i < 3000; i++) begin
      logic mr, mw;
      mr = ($urandom_range(0, 9) < 2);
      mw = !mr && ($urandom_range(0, 9) < 2);
      step(($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 2), mr, mw,
           ($urandom_range(0, 9) < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nErr);
    $finish;
  end
endmodule
